// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch unit: widths, instruction field
// positions, opcodes, FSM states and instruction-decode helpers.
package operand_fetch_unit_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [OPC_MSB-OPC_LSB:0]  opcode_t;

    localparam opcode_t OPC_RTYPE = 6'h00;
    localparam opcode_t OPC_J     = 6'h02;
    localparam opcode_t OPC_JAL   = 6'h03;
    localparam opcode_t OPC_BEQ   = 6'h04;
    localparam opcode_t OPC_BNE   = 6'h05;
    localparam opcode_t OPC_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_OUT
    } state_t;

    typedef struct packed {
        reg_addr_t addr;
        logic      en;
    } dest_t;

    function automatic opcode_t opcode_of(word_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic reg_addr_t rs_of(word_t w);
        return w[RS_MSB:RS_LSB];
    endfunction

    function automatic reg_addr_t rt_of(word_t w);
        return w[RT_MSB:RT_LSB];
    endfunction

    function automatic reg_addr_t rd_of(word_t w);
        return w[RD_MSB:RD_LSB];
    endfunction

    // Instructions without a destination report address 0, so one r0 test disables them all.
    function automatic dest_t dest_of(word_t w);
        dest_t d;
        d = '0;
        case (opcode_of(w))
            OPC_RTYPE:                    d.addr = rd_of(w);
            OPC_JAL:                      d.addr = '1;
            OPC_J, OPC_BEQ, OPC_BNE, OPC_SW: d.addr = '0;
            default:                      d.addr = rt_of(w);
        endcase
        d.en = (d.addr != '0);
        return d;
    endfunction

    function automatic logic rt_is_src(word_t w);
        opcode_t op;
        op = opcode_of(w);
        return (op == OPC_RTYPE) || (op == OPC_SW) || (op == OPC_BEQ) || (op == OPC_BNE);
    endfunction

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Instruction, register-file, operand-bundle and writeback signals of the
// operand fetch unit; slave is the unit's view, master the surroundings.
interface operand_fetch_unit_if;
    import operand_fetch_unit_pkg::*;

    logic      instr_valid;
    word_t     instr;
    logic      instr_ready;
    reg_addr_t rf_addr_r1;
    reg_addr_t rf_addr_r2;
    logic      rf_read;
    word_t     rf_data_r1;
    word_t     rf_data_r2;
    logic      op_valid;
    logic      op_ready;
    word_t     op_instr;
    word_t     op_a;
    word_t     op_b;
    reg_addr_t op_dest;
    logic      op_dest_en;
    logic      wb_valid;
    reg_addr_t wb_addr;

    modport slave (
        input  instr_valid, instr, rf_data_r1, rf_data_r2, op_ready, wb_valid, wb_addr,
        output instr_ready, rf_addr_r1, rf_addr_r2, rf_read,
               op_valid, op_instr, op_a, op_b, op_dest, op_dest_en
    );

    modport master (
        output instr_valid, instr, rf_data_r1, rf_data_r2, op_ready, wb_valid, wb_addr,
        input  instr_ready, rf_addr_r1, rf_addr_r2, rf_read,
               op_valid, op_instr, op_a, op_b, op_dest, op_dest_en
    );

endinterface

// File: rtl/operand_fetch_unit_reg_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set on issue, cleared
// on writeback, with two registered (non-bypassed) hazard query ports.
module reg_scoreboard
    import operand_fetch_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en_i,
    input  reg_addr_t           set_addr_i,
    input  logic                clr_en_i,
    input  reg_addr_t           clr_addr_i,
    input  reg_addr_t           query_a_i,
    input  reg_addr_t           query_b_i,
    output logic                busy_a_o,
    output logic                busy_b_o,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] pending_q;

    // NOTE: combinational blocks start from a full default so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
        // Set is applied after clear so a same-edge set on the same register wins.
        if (set_en_i) pending_d[set_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign busy_a_o  = pending_q[query_a_i];
    assign busy_b_o  = pending_q[query_b_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/operand_fetch_unit.sv
// Decode/operand-fetch stage: captures an instruction, waits out RAW hazards,
// reads the register file and hands an operand bundle to execute.
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_unit_if.slave  bus,
    input  logic                 flush_i,
    output logic [NUM_REGS-1:0]  busy_mask_o
);

    state_t state_q, state_d;
    word_t  instr_q, instr_d;
    word_t  op_a_q, op_a_d;
    word_t  op_b_q, op_b_d;
    logic   op_valid_q, op_valid_d;
    dest_t  dest_q, dest_d;

    logic   rf_read;
    logic   sb_set;
    logic   busy_rs;
    logic   busy_rt;
    logic   hazard;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (sb_set),
        .set_addr_i (dest_q.addr),
        .clr_en_i   (bus.wb_valid),
        .clr_addr_i (bus.wb_addr),
        .query_a_i  (rs_of(instr_q)),
        .query_b_i  (rt_of(instr_q)),
        .busy_a_o   (busy_rs),
        .busy_b_o   (busy_rt),
        .pending_o  (busy_mask_o)
    );

    assign hazard = busy_rs || (rt_is_src(instr_q) && busy_rt);

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        dest_d     = dest_q;
        rf_read    = 1'b0;
        sb_set     = 1'b0;

        case (state_q)
            ST_IDLE: if (bus.instr_valid) begin
                instr_d = bus.instr;
                state_d = ST_CHECK;
            end
            ST_CHECK: if (!hazard) begin
                rf_read = 1'b1;
                state_d = ST_READ;
            end
            ST_READ: begin
                op_a_d     = bus.rf_data_r1;
                op_b_d     = bus.rf_data_r2;
                dest_d     = dest_of(instr_q);
                op_valid_d = 1'b1;
                state_d    = ST_OUT;
            end
            ST_OUT: if (bus.op_ready) begin
                sb_set     = dest_q.en;
                op_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // A flushed instruction is dropped before it can mark its destination busy.
        if (flush_i) begin
            state_d    = ST_IDLE;
            instr_d    = instr_q;
            op_valid_d = 1'b0;
            sb_set     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            dest_q     <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            dest_q     <= dest_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.rf_addr_r1  = rs_of(instr_q);
    assign bus.rf_addr_r2  = rt_of(instr_q);
    assign bus.rf_read     = rf_read;
    assign bus.op_valid    = op_valid_q;
    assign bus.op_instr    = instr_q;
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.op_dest     = dest_q.addr;
    assign bus.op_dest_en  = dest_q.en;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed bench for operand_fetch_unit: a vector table of hazard-free
// instructions followed by hand-written stall, backpressure, flush and reset sequences.
module tb_operand_fetch_unit;
    import operand_fetch_unit_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic [NUM_REGS-1:0] busy_mask;

    operand_fetch_unit_if bus ();

    operand_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush_i     (flush),
        .busy_mask_o (busy_mask)
    );

    always #5 clk = ~clk;

    word_t rf_mem [NUM_REGS];
    assign bus.rf_data_r1 = rf_mem[bus.rf_addr_r1];
    assign bus.rf_data_r2 = rf_mem[bus.rf_addr_r2];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        dest_en;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offers one instruction; returns at posedge+1 of the accept edge.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        check("instr_ready", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int lat;
        lat = 0;
        while (bus.op_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, lat, exp_lat);
    endtask

    task automatic handoff();
        bus.op_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.op_ready = 1'b0;
        check("handoff_op_valid", bus.op_valid, 0);
    endtask

    task automatic writeback(input logic [4:0] addr);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = addr;
        @(posedge clk);
        #1;
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stall_reads;
        int unstable;

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.op_ready    = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = i;

        //            instr         a             b             dest en  mask after handoff
        vecs[0] = '{32'h00221820, 32'h00000001, 32'h00000002, 5'd3,  1'b1, 32'h00000008};
        vecs[1] = '{32'h20250007, 32'h00000001, 32'h00000005, 5'd5,  1'b1, 32'h00000028};
        vecs[2] = '{32'h8C050004, 32'h00000000, 32'h00000005, 5'd5,  1'b1, 32'h00000028};
        vecs[3] = '{32'hAC220008, 32'h00000001, 32'h00000002, 5'd0,  1'b0, 32'h00000028};
        vecs[4] = '{32'h0C000010, 32'h00000000, 32'h00000000, 5'd31, 1'b1, 32'h80000028};
        vecs[5] = '{32'h20200005, 32'h00000001, 32'h00000000, 5'd0,  1'b0, 32'h80000028};
        vecs[6] = '{32'h10220004, 32'h00000001, 32'h00000002, 5'd0,  1'b0, 32'h80000028};
        vecs[7] = '{32'h08000004, 32'h00000000, 32'h00000000, 5'd0,  1'b0, 32'h80000028};

        // Reset state, observed before any clock edge.
        #3;
        check("rst_op_valid",    bus.op_valid, 0);
        check("rst_instr_ready", bus.instr_ready, 1);
        check("rst_rf_read",     bus.rf_read, 0);
        check("rst_rf_addr_r1",  bus.rf_addr_r1, 0);
        check("rst_op_a",        bus.op_a, 0);
        check("rst_op_instr",    bus.op_instr, 0);
        check("rst_op_dest_en",  bus.op_dest_en, 0);
        check("rst_busy_mask",   busy_mask, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].instr);
            wait_valid("vec_latency", 2);
            check("vec_op_instr",   bus.op_instr, vecs[i].instr);
            check("vec_op_a",       bus.op_a, vecs[i].a);
            check("vec_op_b",       bus.op_b, vecs[i].b);
            check("vec_op_dest",    bus.op_dest, vecs[i].dest);
            check("vec_op_dest_en", bus.op_dest_en, vecs[i].dest_en);
            handoff();
            check("vec_busy_mask",  busy_mask, vecs[i].mask);
        end

        // RAW stall: sub r4,r3,r1 waits on r3 until its writeback lands.
        send(32'h00612022);
        stall_reads = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.rf_read !== 1'b0 || bus.op_valid !== 1'b0) stall_reads++;
            @(posedge clk);
            #1;
        end
        check("raw_stall_rf_read", stall_reads, 0);
        check("raw_rf_addr_r1", bus.rf_addr_r1, 3);
        check("raw_rf_addr_r2", bus.rf_addr_r2, 1);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        rf_mem[3]    = 32'hDEAD0003;
        #1;
        check("raw_no_bypass", bus.rf_read, 0);
        @(posedge clk);
        #1;
        bus.wb_valid = 1'b0;
        check("raw_read_after_wb", bus.rf_read, 1);
        wait_valid("raw_latency", 2);
        check("raw_op_a",    bus.op_a, 32'hDEAD0003);
        check("raw_op_b",    bus.op_b, 1);
        check("raw_op_dest", bus.op_dest, 4);
        handoff();
        check("raw_busy_mask", busy_mask, 32'h80000030);

        // Backpressure: bundle must hold even though the register file changes underneath.
        send(32'h00223020);
        wait_valid("bp_latency", 2);
        rf_mem[1] = 32'h11111111;
        unstable  = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.op_valid !== 1'b1 || bus.op_a !== 32'h1 || bus.op_b !== 32'h2 ||
                bus.op_dest !== 5'd6 || bus.op_instr !== 32'h00223020) unstable++;
        end
        check("bp_stable_cycles", unstable, 0);
        rf_mem[1] = 32'h1;

        // Flush beats a simultaneous handoff: r6 must never become pending.
        flush        = 1'b1;
        bus.op_ready = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.op_ready = 1'b0;
        check("flush_op_valid",    bus.op_valid, 0);
        check("flush_instr_ready", bus.instr_ready, 1);
        check("flush_busy_mask",   busy_mask, 32'h80000030);

        // Same-edge set and clear of r7: set wins.
        send(32'h20270001);
        wait_valid("setclr_latency", 2);
        bus.op_ready = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd7;
        @(posedge clk);
        #1;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b0;
        check("setclr_busy_mask", busy_mask, 32'h800000B0);

        writeback(5'd0);
        check("wb_r0_ignored", busy_mask, 32'h800000B0);
        writeback(5'd5);
        check("wb_r5_clear", busy_mask, 32'h80000090);

        // sw reads rt as a source, so a pending r7 must stall it.
        send(32'hAC270000);
        @(posedge clk);
        #1;
        check("sw_rt_stall", bus.rf_read, 0);
        writeback(5'd7);
        check("sw_read_after_wb", bus.rf_read, 1);
        wait_valid("sw_latency", 2);
        check("sw_op_b", bus.op_b, 7);
        handoff();
        check("sw_busy_mask", busy_mask, 32'h80000010);

        // Asynchronous reset while the unit sits in READ, away from any clock edge.
        send(32'h00224020);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_op_valid",    bus.op_valid, 0);
        check("arst_busy_mask",   busy_mask, 0);
        check("arst_instr_ready", bus.instr_ready, 1);
        check("arst_rf_read",     bus.rf_read, 0);
        check("arst_rf_addr_r1",  bus.rf_addr_r1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'h00221820);
        wait_valid("post_reset_latency", 2);
        check("post_reset_op_a", bus.op_a, 1);
        handoff();
        check("post_reset_busy_mask", busy_mask, 32'h00000008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Decode/operand-fetch stage directly upstream of the 32x32 register file read ports.
- Accepts one instruction word at a time and drives the register file read addresses and READ strobe.
- Latches DATA_R1/DATA_R2 and presents an operand bundle to execute over a valid/ready handshake.
- Holds a 32-entry pending-write scoreboard so that no operand is fetched before an earlier writeback to the same register completes.

Parameters:
DATA_WIDTH, 32, operand and instruction width
REG_ADDR_WIDTH, 5, register address width (32 registers)

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-low reset
INSTR_VALID  in  1  instruction offered
INSTR  in  32  instruction word
INSTR_READY  out  1  unit can accept instruction
RF_ADDR_R1  out  5  register file read address 1 (rs)
RF_ADDR_R2  out  5  register file read address 2 (rt)
RF_READ  out  1  register file read strobe
RF_DATA_R1  in  32  register file read data 1
RF_DATA_R2  in  32  register file read data 2
OP_VALID  out  1  operand bundle valid
OP_READY  in  1  execute accepts bundle
OP_INSTR  out  32  captured instruction
OP_A  out  32  rs value
OP_B  out  32  rt value
OP_DEST  out  5  destination register
OP_DEST_EN  out  1  instruction writes a register
WB_VALID  in  1  writeback completing this cycle
WB_ADDR  in  5  writeback register
FLUSH  in  1  synchronous discard of the in-flight instruction
BUSY_MASK  out  32  scoreboard pending bits

Behaviour:
- Reset (RST=0, async):
  - State IDLE; pending=0.
  - OP_VALID=0; OP_A, OP_B, OP_INSTR, OP_DEST, OP_DEST_EN = 0.
  - RF_READ=0; RF_ADDR_R1/R2=0; INSTR_READY=1 (combinational: state==IDLE).
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11].
- Destination:
  - R-type (opcode 0x00): rd.
  - jal (0x03): 31.
  - j (0x02), beq (0x04), bne (0x05), sw (0x2B): none.
  - All other I-types: rt.
  - A destination of 0 forces OP_DEST_EN=0.
- Sources:
  - rs is always a source.
  - rt is a source only for R-type, sw, beq, bne.
  - Register 0 never creates a hazard.
- FSM:
  - IDLE: INSTR_VALID&INSTR_READY at an edge captures INSTR and moves to CHECK.
  - CHECK: RF_ADDR_R1=rs and RF_ADDR_R2=rt are held from here through READ.
    - Hazard (any source register pending): stay in CHECK, RF_READ=0.
    - Otherwise: RF_READ=1, move to READ.
  - READ: RF_DATA valid during this cycle; the next edge latches OP_A/OP_B, sets OP_VALID=1 and moves to OUT.
  - OUT: hold all OP_* stable while OP_VALID=1 and OP_READY=0. On OP_VALID&OP_READY at an edge:
    - set pending[OP_DEST] if OP_DEST_EN;
    - OP_VALID->0; move to IDLE.
- Latency:
  - OP_VALID rises 2 edges after the accept edge when no hazard is present.
  - Throughput is at most one instruction per 4 cycles.
- Scoreboard:
  - WB_VALID clears pending[WB_ADDR] at the edge; the cleared bit is first visible to the hazard check in the following cycle (no bypass).
  - Simultaneous set and clear of the same address: set wins.
  - WB_VALID with WB_ADDR=0 is ignored.
  - pending[0] is always 0.
- FLUSH:
  - Edge with FLUSH=1 forces IDLE and OP_VALID=0.
  - Pending bits are untouched; a flushed instruction never sets pending.
  - FLUSH has priority over the OUT handshake.
- Mid-operation reset: RST=0 immediately returns all state and outputs to reset values, independent of CLK.

Decomposition:
- Shared definitions header:
  - opcode constants;
  - field bit positions;
  - DATA_WIDTH and REG_ADDR_WIDTH;
  - FSM state encodings.
- One sub-module, reg_scoreboard:
  - 32-bit pending vector with set/clear ports and two hazard-query ports;
  - set-wins priority implemented inside it.

Test Plan:
- Basic fetch: RF r1=1, r2=2; INSTR=0x00221820 (add r3,r1,r2) -> OP_VALID 2 edges after accept; OP_A=1, OP_B=2, OP_DEST=3, OP_DEST_EN=1; after handoff BUSY_MASK=0x00000008.
- RAW stall: after the above, INSTR=0x00612022 (sub r4,r3,r1) -> RF_READ stays 0 in CHECK. WB_VALID=1, WB_ADDR=3 for one cycle -> RF_READ=1 the cycle after, OP_A equals the new r3 value, BUSY_MASK=0x00000010 after handoff.
- Non-source rt: r5 pending, INSTR=0x8C050004 (lw r5,4(r0)) -> no stall; OP_DEST=5, OP_DEST_EN=1.
- No-dest and r0 cases:
  - sw (0x2B) -> OP_DEST_EN=0, pending unchanged.
  - jal 0x0C000010 -> OP_DEST=31.
  - addi r0 -> OP_DEST_EN=0.
- Backpressure and flush:
  - OP_READY=0 for 5 cycles -> OP_* stable throughout.
  - FLUSH=1 -> IDLE, OP_VALID=0, BUSY_MASK unchanged.
  - Set/clear same register on the same edge -> bit remains set.
- Async reset: RST=0 during READ, between clock edges -> OP_VALID=0, BUSY_MASK=0, INSTR_READY=1 immediately.
